// File: rtl/fifo_pkg.sv
// Shared helpers for the width-upsizing FIFO family: width calculation,
// parameter legality and the default wide-word width.
package fifo_pkg;

  localparam int unsigned OUT_W_DEFAULT = 64;

  function automatic int unsigned fp_clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

  function automatic bit fifo_params_ok(input int unsigned ratio,
                                        input int unsigned depth,
                                        input int unsigned af_thresh);
    return (ratio >= 2) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af_thresh >= 1) && (af_thresh <= depth);
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// DEPTH x W storage array: synchronous write port, asynchronous read port.
module sfifo_ram #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/fifo_pack.sv
// Width-upsizing FIFO: packs RATIO narrow words little-endian into one wide
// word, stores wide words in a circular buffer, show-ahead read side.
module fifo_pack
  import fifo_pkg::*;
#(
  parameter int unsigned IN_W      = OUT_W_DEFAULT / 4,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [IN_W-1:0]                  wr_data,
  output logic                             wr_full,
  input  logic                             flush,
  input  logic                             rd_en,
  output logic                             data_valid,
  output logic [IN_W*RATIO-1:0]            up_data,
  output logic [fp_clog2(DEPTH+1)-1:0]     level,
  output logic                             almost_full,
  output logic                             overflow
);

  localparam int unsigned OUT_W = IN_W * RATIO;
  localparam int unsigned PW    = fp_clog2(DEPTH);
  localparam int unsigned LW    = fp_clog2(DEPTH + 1);
  localparam int unsigned CW    = fp_clog2(RATIO);

  if (!fifo_params_ok(RATIO, DEPTH, AF_THRESH)) begin : g_bad_params
    $error("fifo_pack: illegal RATIO/DEPTH/AF_THRESH combination");
  end

  logic [OUT_W-1:0] r_pack;
  logic [CW-1:0]    r_pack_cnt;
  logic             r_flush_pend;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_almost_full;
  logic             r_overflow;

  logic [OUT_W-1:0] w_pack_merged;
  logic [OUT_W-1:0] w_rdata;
  logic [LW-1:0]    w_level_nxt;
  logic             w_store_full;
  logic             w_last_lane;
  logic             w_accept;
  logic             w_complete;
  logic             w_flush_req;
  logic             w_push;
  logic             w_pop;

  assign w_store_full = (r_level == LW'(DEPTH));
  assign w_last_lane  = (r_pack_cnt == CW'(RATIO - 1));
  // A pending flush freezes the pack so the deferred push sees exactly what was flushed.
  assign wr_full      = (w_store_full && w_last_lane) || r_flush_pend;
  assign w_accept     = wr_en && !wr_full;
  assign w_complete   = w_accept && w_last_lane;
  assign w_flush_req  = (flush && !w_complete && (w_accept || (r_pack_cnt != '0)))
                        || r_flush_pend;
  assign w_push       = w_complete || (w_flush_req && !w_store_full);
  assign w_pop        = rd_en && (r_level != '0);

  always_comb begin
    w_pack_merged = r_pack;
    if (w_accept) begin
      for (int unsigned k = 0; k < RATIO; k++) begin
        if (r_pack_cnt == CW'(k)) w_pack_merged[k*IN_W +: IN_W] = wr_data;
      end
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pack        <= '0;
      r_pack_cnt    <= '0;
      r_flush_pend  <= 1'b0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_level       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_level       <= w_level_nxt;
      r_almost_full <= (w_level_nxt >= LW'(AF_THRESH));
      if (wr_en && wr_full) r_overflow <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push) begin
        r_pack       <= '0;
        r_pack_cnt   <= '0;
        r_flush_pend <= 1'b0;
      end else begin
        if (w_accept) begin
          r_pack     <= w_pack_merged;
          r_pack_cnt <= r_pack_cnt + 1'b1;
        end
        if (w_flush_req) r_flush_pend <= 1'b1;
      end
    end
  end

  sfifo_ram #(
    .W     (OUT_W),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wptr),
    .wdata (w_pack_merged),
    .raddr (r_rptr),
    .rdata (w_rdata)
  );

  assign data_valid  = (r_level != '0);
  assign up_data     = data_valid ? w_rdata : '0;
  assign level       = r_level;
  assign almost_full = r_almost_full;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_fifo_pack.sv
// Bench for fifo_pack: constant vector table for basic pack/flush, plus a
// queue scoreboard fed by a packing model, checked every cycle.
module tb_fifo_pack;

  localparam int IN_W  = 16;
  localparam int RATIO = 4;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int OUT_W = IN_W * RATIO;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [IN_W-1:0]  wr_data;
  logic             wr_full;
  logic             flush;
  logic             rd_en;
  logic             data_valid;
  logic [OUT_W-1:0] up_data;
  logic [3:0]       level;
  logic             almost_full;
  logic             overflow;

  always #5 clk = ~clk;

  fifo_pack #(
    .IN_W      (IN_W),
    .RATIO     (RATIO),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_full     (wr_full),
    .flush       (flush),
    .rd_en       (rd_en),
    .data_valid  (data_valid),
    .up_data     (up_data),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard of expected wide words plus packing model state
  logic [OUT_W-1:0] q[$];
  logic [OUT_W-1:0] m_pack;
  int               m_cnt;
  bit               m_pend;
  bit               m_ovf;

  typedef struct {
    bit               we;
    logic [IN_W-1:0]  d;
    bit               fl;
    bit               re;
    bit               exp_dv;
    logic [OUT_W-1:0] exp_data;
    int               exp_lvl;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit m_full();
    return ((q.size() == DEPTH) && (m_cnt == RATIO - 1)) || m_pend;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pack = '0;
    m_cnt  = 0;
    m_pend = 0;
    m_ovf  = 0;
  endtask

  task automatic check_outputs();
    logic [OUT_W-1:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    chk("level",       64'(level),       64'(q.size()));
    chk("data_valid",  64'(data_valid),  64'(q.size() > 0));
    chk("up_data",     up_data,          head);
    chk("wr_full",     64'(wr_full),     64'(m_full()));
    chk("almost_full", 64'(almost_full), 64'(q.size() >= AF));
    chk("overflow",    64'(overflow),    64'(m_ovf));
  endtask

  task automatic cyc(input bit we, input logic [IN_W-1:0] d, input bit fl, input bit re);
    int pre;
    bit full, acc, comp, freq, pop;
    @(negedge clk);
    check_outputs();
    wr_en = we; wr_data = d; flush = fl; rd_en = re;
    pre  = q.size();
    full = m_full();
    if (we && full) m_ovf = 1;
    acc = we && !full;
    pop = re && (pre > 0);
    if (acc) begin
      m_pack[m_cnt*IN_W +: IN_W] = d;
      m_cnt++;
    end
    comp = acc && (m_cnt == RATIO);
    if (pop) void'(q.pop_front());
    if (comp) begin
      q.push_back(m_pack);
      m_pack = '0;
      m_cnt  = 0;
    end
    freq = (fl && !comp && (m_cnt != 0)) || m_pend;
    if (freq) begin
      if (pre < DEPTH) begin
        q.push_back(m_pack);
        m_pack = '0;
        m_cnt  = 0;
        m_pend = 0;
      end else begin
        m_pend = 1;
      end
    end
    @(posedge clk);
    #1;
    wr_en = 0; wr_data = '0; flush = 0; rd_en = 0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 1);
  endtask

  task automatic write_n(input int n, input logic [IN_W-1:0] base);
    for (int i = 0; i < n; i++) cyc(1, base + IN_W'(i), 0, 0);
  endtask

  initial begin
    vecs[0] = '{1, 16'h0001, 0, 0, 0, 64'h0, 0};
    vecs[1] = '{1, 16'h0002, 0, 0, 0, 64'h0, 0};
    vecs[2] = '{1, 16'h0003, 0, 0, 0, 64'h0, 0};
    vecs[3] = '{1, 16'h0004, 0, 0, 1, 64'h0004_0003_0002_0001, 1};
    vecs[4] = '{0, 16'h0000, 0, 1, 0, 64'h0, 0};
    vecs[5] = '{1, 16'hAAAA, 0, 0, 0, 64'h0, 0};
    vecs[6] = '{1, 16'hBBBB, 0, 0, 0, 64'h0, 0};
    vecs[7] = '{0, 16'h0000, 1, 0, 1, 64'h0000_0000_BBBB_AAAA, 1};
    vecs[8] = '{0, 16'h0000, 1, 0, 1, 64'h0000_0000_BBBB_AAAA, 1};
    vecs[9] = '{0, 16'h0000, 0, 1, 0, 64'h0, 0};

    rst = 1; wr_en = 0; wr_data = '0; flush = 0; rd_en = 0;
    model_reset();
    #12;
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_dv",    64'(data_valid), 64'd0);
    chk("reset_full",  64'(wr_full), 64'd0);
    chk("reset_data",  up_data, 64'd0);
    rst = 0;

    // basic pack and flush vectors
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].we, vecs[i].d, vecs[i].fl, vecs[i].re);
      chk($sformatf("vec%0d_dv", i),   64'(data_valid), 64'(vecs[i].exp_dv));
      chk($sformatf("vec%0d_data", i), up_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_lvl", i),  64'(level), 64'(vecs[i].exp_lvl));
    end

    // fill, overflow, sticky overflow
    write_n(32, 16'h0100);
    chk("fill_level", 64'(level), 64'd8);
    chk("fill_af",    64'(almost_full), 64'd1);
    write_n(3, 16'h0200);
    chk("full_after_3", 64'(wr_full), 64'd1);
    cyc(1, 16'hDEAD, 0, 0);
    chk("overflow_set", 64'(overflow), 64'd1);
    drain(2);
    chk("overflow_sticky", 64'(overflow), 64'd1);
    drain(6);
    cyc(0, '0, 1, 0);
    drain(2);

    // deferred flush at full storage
    write_n(32, 16'h0300);
    cyc(1, 16'h4444, 0, 0);
    cyc(0, '0, 1, 0);
    chk("defer_full",  64'(wr_full), 64'd1);
    chk("defer_level", 64'(level), 64'd8);
    cyc(0, '0, 0, 1);
    chk("defer_pop_level", 64'(level), 64'd7);
    cyc(0, '0, 0, 0);
    chk("defer_push_level", 64'(level), 64'd8);
    drain(7);
    chk("defer_padded", up_data, 64'h0000_0000_0000_4444);
    drain(2);

    // simultaneous push/pop, then long stream through pointer wrap
    write_n(12, 16'h0500);
    write_n(3, 16'h0600);
    cyc(1, 16'h0603, 0, 1);
    chk("pushpop_level", 64'(level), 64'd3);
    drain(3);
    for (int i = 0; i < 160; i++) cyc(1, IN_W'($urandom), 0, 1);
    drain(3);

    // async reset mid-stream
    write_n(22, 16'h0700);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("arst_level",    64'(level), 64'd0);
    chk("arst_dv",       64'(data_valid), 64'd0);
    chk("arst_data",     up_data, 64'd0);
    chk("arst_full",     64'(wr_full), 64'd0);
    chk("arst_af",       64'(almost_full), 64'd0);
    chk("arst_overflow", 64'(overflow), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
    cyc(1, 16'h1111, 0, 0);
    cyc(1, 16'h2222, 0, 0);
    cyc(1, 16'h3333, 0, 0);
    cyc(1, 16'h4444, 0, 0);
    chk("fresh_word", up_data, 64'h4444_3333_2222_1111);
    drain(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_pack.md
Name: fifo_pack

Overview:
Parametrised single-clock width-upsizing FIFO, the successor to the fixed 64-bit demo FIFO.
- Input side: packs RATIO narrow input words (IN_W bits) into one wide word (OUT_W = IN_W*RATIO, 64 by default).
- Storage: wide words are held in a DEPTH-entry circular buffer.
- Output side: wide words are presented as up_data/data_valid with a show-ahead read handshake.
- Adds features the fixed demo FIFO lacks: partial-word flush, occupancy level, almost-full threshold and sticky overflow.

Parameters:
IN_W, 16, input word width in bits.
RATIO, 4, input words per output word; must be >= 2. OUT_W = IN_W*RATIO.
DEPTH, 8, wide-word storage entries; must be a power of two >= 2.
AF_THRESH, 6, almost_full asserts when level >= AF_THRESH; range 1..DEPTH.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
wr_en  in  1  write request for wr_data.
wr_data  in  IN_W  narrow input word.
wr_full  out  1  input word cannot be accepted this cycle.
flush  in  1  push the partial pack, zero-padded.
rd_en  in  1  pop the head word (show-ahead).
data_valid  out  1  storage non-empty; up_data is valid.
up_data  out  OUT_W  head wide word.
level  out  $clog2(DEPTH+1)  stored wide-word count.
almost_full  out  1  level >= AF_THRESH.
overflow  out  1  sticky: a write was attempted while wr_full.

Behaviour:
- Reset (async assert): wr_full=0, data_valid=0, up_data=0, level=0, almost_full=0, overflow=0. Pack register and pack_cnt are cleared, read/write pointers are cleared, and the partial pack is discarded. Memory contents are don't-care.
- Write accept: accepted when wr_en && !wr_full.
- Pack order: little-endian. The word accepted at pack_cnt=k lands in bits [IN_W*(k+1)-1 : IN_W*k]. pack_cnt then increments.
- Push on completion: when the word accepted at pack_cnt=RATIO-1 completes the pack, the full wide word is pushed into storage on that same edge. pack_cnt wraps to 0 and the pack register clears.
- wr_full: wr_full = (level==DEPTH) && (pack_cnt==RATIO-1).
  - It does not credit a same-cycle pop.
  - Words that only partially fill the pack are accepted even while storage is full.
- Overflow: overflow is set on any cycle with wr_en && wr_full. The offending word is dropped. overflow is cleared only by rst.
- Flush, normal case: flush with pack_cnt>0 and level<DEPTH pushes the pack register with unfilled lanes zero, then pack_cnt returns to 0.
- Flush with wr_en in the same cycle: the accepted word is merged first, then flushed. If that word completes the pack, it is a normal push and the flush has no extra effect.
- Flush, ignored cases: flush with pack_cnt==0 (and no same-cycle accept) is ignored.
- Flush, storage full: flush with level==DEPTH sets an internal flush_pend.
  - The push occurs on the first cycle level<DEPTH.
  - While flush_pend is set, wr_full=1 to freeze the pack.
- Read, show-ahead:
  - data_valid = (level>0).
  - up_data = head entry when data_valid, else 0.
  - rd_en && data_valid pops on the edge.
  - rd_en while empty is ignored and does not underflow.
- Latency: a completing write or flush at edge N gives data_valid=1 and the new head after edge N, provided storage was empty. There is no fall-through bypass.
- Simultaneous push and pop: level unchanged, both pointers advance, and order is preserved. At level==DEPTH, a pop plus a partial write is legal.
- Pointers: $clog2(DEPTH) bits, wrapping modulo DEPTH. level is a separate counter: +1 on push only, -1 on pop only, unchanged on both.
- almost_full is registered from the next-state level, so it is consistent with level every cycle.

Decomposition:
- Shared package fifo_pkg: a clog2-style width helper, a parameter legality check (RATIO>=2, DEPTH power of two, AF_THRESH range) and a default OUT_W constant of 64.
- One sub-module, sfifo_ram: DEPTH x OUT_W storage with write port (we, waddr, wdata) and asynchronous read (raddr -> rdata).
- fifo_pack owns the pack register, pack_cnt, flush_pend, pointers and flags.

Test Plan:
All cases use IN_W=16, RATIO=4, DEPTH=8, AF_THRESH=6.
1. Basic pack: write 0x0001,0x0002,0x0003,0x0004 on consecutive cycles -> the next cycle shows data_valid=1, up_data=64'h0004_0003_0002_0001, level=1; rd_en one cycle -> data_valid=0, up_data=0.
2. Full and overflow: write 32 words with no reads -> level=8, almost_full=1 (from level 6 onward). Write 3 more -> accepted. 4th write -> wr_full=1, word dropped, overflow=1 and stays 1 after later reads.
3. Flush: write 0xAAAA,0xBBBB then flush -> up_data=64'h0000_0000_BBBB_AAAA. A second flush with pack_cnt=0 leaves level unchanged.
4. Deferred flush: at level=8 with 1 word packed, flush -> no push and wr_full=1. Pop one -> the following cycle level returns to 8 and the last entry is zero-padded.
5. Simultaneous push and pop at level=3 -> level stays 3. Over a 40-wide-word continuous stream with rd_en=1, the output order matches input (pointer wrap).
6. Async reset mid-stream with 2 words packed and level=5 -> all outputs 0 immediately. After release, the next 4 writes form a fresh word with no stale lanes.
